// File: rtl/vmicro16_bram_dp.sv
// vmicro16_bram_dp
//   True dual-port synchronous block RAM for the vmicro16 SoC. Two independent
//   req/ready ports share one array. After reset the array can be zero-cleared
//   one word per cycle before either port becomes ready.
//
//   State table
//     S_CLEAR | writing zero to mem[cnt], ports not ready
//     S_RUN   | normal operation, both ports ready
//
// Ports
//   clk                   rising-edge clock
//   reset                 asynchronous, active-low reset
//   a_req / b_req         request strobe, accepted when ready is high
//   a_we / b_we           write enable, qualified by req
//   a_addr / b_addr       word address (>= MEM_DEPTH is out of range)
//   a_wdata / b_wdata     write data
//   a_ready / b_ready     port accepts a request this cycle
//   a_rvalid / b_rvalid   one-cycle read-data strobe
//   a_rdata / b_rdata     read data, held until the next rvalid
module vmicro16_bram_dp #(
    parameter int MEM_WIDTH      = 16,
    parameter int MEM_DEPTH      = 256,
    parameter int ADDR_BITS      = 8,
    parameter int RDW_MODE       = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 a_req,
    input  logic                 a_we,
    input  logic [ADDR_BITS-1:0] a_addr,
    input  logic [MEM_WIDTH-1:0] a_wdata,
    output logic                 a_ready,
    output logic                 a_rvalid,
    output logic [MEM_WIDTH-1:0] a_rdata,
    input  logic                 b_req,
    input  logic                 b_we,
    input  logic [ADDR_BITS-1:0] b_addr,
    input  logic [MEM_WIDTH-1:0] b_wdata,
    output logic                 b_ready,
    output logic                 b_rvalid,
    output logic [MEM_WIDTH-1:0] b_rdata
);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
    // The counter is one bit wider than an address so a power-of-two depth
    // still has a representable terminal value.
    localparam logic [ADDR_BITS:0] DEPTH_C = (ADDR_BITS+1)'(MEM_DEPTH);
    localparam logic [ADDR_BITS:0] LAST_C  = (ADDR_BITS+1)'(MEM_DEPTH - 1);

    state_t               state, state_nxt;
    logic [ADDR_BITS:0]   cnt, cnt_nxt;
    logic                 ready;

    logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

    logic [1:0]                 req, we, acc, inr, wr, rsp_v, v1, rvalid;
    logic [1:0][ADDR_BITS-1:0]  addr;
    logic [1:0][MEM_WIDTH-1:0]  wdata, old, newv, rsp_d, d1, rdata;
    logic                       same_wr;

    assign req   = {b_req, a_req};
    assign we    = {b_we, a_we};
    assign addr  = {b_addr, a_addr};
    assign wdata = {b_wdata, a_wdata};

    // ---------------- sequencer ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RESET_STATE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_CLEAR: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST_C)
                    state_nxt = S_RUN;
            end
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = RESET_STATE;
        endcase
    end

    assign ready   = (state == S_RUN);
    assign a_ready = ready;
    assign b_ready = ready;

    // ---------------- access decode ----------------
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            acc[p] = req[p] & ready;
            inr[p] = {1'b0, addr[p]} < DEPTH_C;
            wr[p]  = acc[p] & we[p] & inr[p];
            old[p] = inr[p] ? mem[addr[p]] : '0;
        end
    end

    // Port A wins a same-address write collision, so B's "new" data is A's.
    assign same_wr = wr[0] & wr[1] & (addr[0] == addr[1]);
    assign newv[0] = wdata[0];
    assign newv[1] = same_wr ? wdata[0] : wdata[1];

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rsp_v[p] = 1'b0;
            rsp_d[p] = old[p];
            if (acc[p]) begin
                if (!we[p]) begin
                    rsp_v[p] = 1'b1;
                end else if (RDW_MODE == 0) begin
                    rsp_v[p] = 1'b1;
                    rsp_d[p] = inr[p] ? newv[p] : '0;
                end else if (RDW_MODE == 1) begin
                    rsp_v[p] = 1'b1;
                end
            end
        end
    end

    // ---------------- array (not reset) ----------------
    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            mem[cnt[ADDR_BITS-1:0]] <= '0;
        end else begin
            if (wr[1] && !same_wr)
                mem[addr[1]] <= wdata[1];
            if (wr[0])
                mem[addr[0]] <= wdata[0];
        end
    end

    // ---------------- response pipeline ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1 <= '0;
            d1 <= '0;
        end else begin
            v1 <= rsp_v;
            for (int p = 0; p < 2; p++)
                if (rsp_v[p])
                    d1[p] <= rsp_d[p];
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [1:0]                v2;
            logic [1:0][MEM_WIDTH-1:0] d2;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    v2 <= '0;
                    d2 <= '0;
                end else begin
                    v2 <= v1;
                    for (int p = 0; p < 2; p++)
                        if (v1[p])
                            d2[p] <= d1[p];
                end
            end

            assign rvalid = v2;
            assign rdata  = d2;
        end else begin : g_no_out_reg
            assign rvalid = v1;
            assign rdata  = d1;
        end
    endgenerate

    assign a_rvalid = rvalid[0];
    assign b_rvalid = rvalid[1];
    assign a_rdata  = rdata[0];
    assign b_rdata  = rdata[1];

endmodule
